// File: rtl/ascii_line_receiver_if.sv
// ascii_line_receiver_if: character stream in, FIFO stream out, per-line statistics
//   in_data/in_valid/in_ready     : incoming character handshake
//   out_data/out_valid/out_ready  : buffered character stream (first-word fall-through)
//   line_done, line_len, line_xor, line_words, line_ext, line_ovf : statistics of last line
interface ascii_line_receiver_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       line_done;
   logic [7:0] line_len;
   logic [7:0] line_xor;
   logic [7:0] line_words;
   logic       line_ext;
   logic       line_ovf;
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, line_done, line_len, line_xor, line_words, line_ext, line_ovf
   );
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, line_done, line_len, line_xor, line_words, line_ext, line_ovf
   );
endinterface

// File: rtl/ascii_line_receiver.sv
// ascii_line_receiver: buffers newline-delimited ASCII in a FIFO and reports per-line statistics
//   clk   : clock
//   rst_n : asynchronous reset, active high
//   bus   : slave side of ascii_line_receiver_if (input stream, FIFO output, line_* statistics)
module ascii_line_receiver #(
   parameter int DEPTH = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   ascii_line_receiver_if.slave bus
);
   localparam int aw = $clog2(DEPTH);
   localparam logic [aw:0] full_cnt = (aw+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, LINE, REPORT} state_t;
   state_t state, state_nxt;
   logic [7:0] mem [DEPTH];
   logic [aw-1:0] wr_ptr, rd_ptr;
   logic [aw:0] count;
   logic [7:0] run_len, run_xor, run_words;
   logic run_ext, run_ovf, at_gap;
   logic accept, is_nl, push, pop;
   assign is_nl = bus.in_data == 8'h0A;
   // ready depends only on registered count, so a same-cycle pop never frees room for a push
   assign bus.in_ready = !rst_n && count < full_cnt && state != REPORT;
   assign accept = bus.in_valid && bus.in_ready;
   assign push = accept && !is_nl;
   assign pop = bus.out_valid && bus.out_ready;
   assign bus.out_valid = count != '0;
   assign bus.out_data = mem[rd_ptr];
   assign bus.line_done = state == REPORT;
   always_comb begin
      state_nxt = state;
      if (state == REPORT) state_nxt = IDLE;
      else if (accept) state_nxt = is_nl ? REPORT : LINE;
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end
   // at_gap marks "previous byte was a space or the line just started"
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         run_len <= '0;
         run_xor <= '0;
         run_words <= '0;
         run_ext <= 1'b0;
         run_ovf <= 1'b0;
         at_gap <= 1'b1;
         bus.line_len <= '0;
         bus.line_xor <= '0;
         bus.line_words <= '0;
         bus.line_ext <= 1'b0;
         bus.line_ovf <= 1'b0;
      end else if (accept && is_nl) begin
         bus.line_len <= run_len;
         bus.line_xor <= run_xor;
         bus.line_words <= run_words;
         bus.line_ext <= run_ext;
         bus.line_ovf <= run_ovf;
         run_len <= '0;
         run_xor <= '0;
         run_words <= '0;
         run_ext <= 1'b0;
         run_ovf <= 1'b0;
         at_gap <= 1'b1;
      end else if (accept) begin
         run_len <= run_len == 8'hFF ? 8'hFF : run_len + 1'b1;
         run_ovf <= run_ovf || run_len == 8'hFF;
         run_xor <= run_xor ^ bus.in_data;
         run_ext <= run_ext || bus.in_data[7];
         run_words <= at_gap && bus.in_data != 8'h20 && run_words != 8'hFF ? run_words + 1'b1 : run_words;
         at_gap <= bus.in_data == 8'h20;
      end
   end
endmodule

// File: tb/tb_ascii_line_receiver.sv
// tb_ascii_line_receiver: randomized and directed stimulus checked against a queue-based line model
module tb_ascii_line_receiver;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   ascii_line_receiver_if bus();
   ascii_line_receiver #(.DEPTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int total = 0;
   int bad = 0;
   byte unsigned tx_q[$];
   byte unsigned fifo_q[$];
   byte unsigned line_q[$];
   logic rep = 1'b0;
   logic [7:0] e_len = '0, e_xor = '0, e_words = '0;
   logic e_ext = 1'b0, e_ovf = 1'b0;
   int mode = 1;
   int gap_pct = 0;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic clear_model();
      fifo_q.delete();
      line_q.delete();
      rep = 1'b0;
      e_len = '0;
      e_xor = '0;
      e_words = '0;
      e_ext = 1'b0;
      e_ovf = 1'b0;
   endtask
   task automatic line_stats();
      int n, w;
      n = line_q.size();
      w = 0;
      e_xor = '0;
      e_ext = 1'b0;
      foreach (line_q[i]) begin
         e_xor ^= line_q[i];
         e_ext |= line_q[i][7];
         if (line_q[i] != 8'h20 && (i == 0 || line_q[i-1] == 8'h20)) w++;
      end
      e_len = n > 255 ? 8'd255 : 8'(n);
      e_ovf = n > 255;
      e_words = w > 255 ? 8'd255 : 8'(w);
   endtask
   task automatic cycle();
      logic exp_rdy, acc, pp;
      byte unsigned b;
      bus.in_valid = tx_q.size() != 0 && $urandom_range(99) >= gap_pct;
      bus.in_data = tx_q.size() != 0 ? tx_q[0] : 8'($urandom);
      bus.out_ready = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : 1'($urandom_range(1));
      @(negedge clk);
      exp_rdy = !rst_n && fifo_q.size() < 16 && !rep;
      check("in_ready", bus.in_ready, exp_rdy);
      check("out_valid", bus.out_valid, fifo_q.size() != 0);
      if (fifo_q.size() != 0) check("out_data", bus.out_data, fifo_q[0]);
      check("line_done", bus.line_done, rep);
      check("line_len", bus.line_len, e_len);
      check("line_xor", bus.line_xor, e_xor);
      check("line_words", bus.line_words, e_words);
      check("line_ext", bus.line_ext, e_ext);
      check("line_ovf", bus.line_ovf, e_ovf);
      if (!rst_n) begin
         acc = bus.in_valid && exp_rdy;
         pp = bus.out_ready && fifo_q.size() != 0;
         rep = 1'b0;
         if (pp) void'(fifo_q.pop_front());
         if (acc) begin
            b = tx_q.pop_front();
            if (b == 8'h0A) begin
               line_stats();
               line_q.delete();
               rep = 1'b1;
            end else begin
               line_q.push_back(b);
               fifo_q.push_back(b);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset(int n);
      rst_n = 1'b1;
      clear_model();
      repeat (n) cycle();
      rst_n = 1'b0;
   endtask
   task automatic send(string s);
      foreach (s[i]) tx_q.push_back(s[i]);
   endtask
   task automatic run(int max_cycles);
      int c = 0;
      while ((tx_q.size() != 0 || (mode != 0 && fifo_q.size() != 0) || rep) && c < max_cycles) begin
         cycle();
         c++;
      end
      check("drain", tx_q.size() == 0 && (mode == 0 || fifo_q.size() == 0), 1);
   endtask
   function automatic byte unsigned rnd_ch();
      int r;
      r = $urandom_range(99);
      if (r < 20) return 8'h20;
      if (r < 30) return 8'($urandom_range(255, 128));
      return 8'($urandom_range(126, 33));
   endfunction
   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      do_reset(3);
      mode = 1;
      send("Hi\n");
      run(50);
      check("hi_len", bus.line_len, 8'd2);
      check("hi_xor", bus.line_xor, 8'h21);
      check("hi_words", bus.line_words, 8'd1);
      check("hi_ext", bus.line_ext, 1'b0);
      send("a  b\n");
      run(50);
      check("ab_len", bus.line_len, 8'd4);
      check("ab_xor", bus.line_xor, 8'h03);
      check("ab_words", bus.line_words, 8'd2);
      send("\n");
      run(20);
      check("empty_len", bus.line_len, 8'd0);
      check("empty_words", bus.line_words, 8'd0);
      mode = 0;
      repeat (17) tx_q.push_back(8'h78);
      repeat (20) cycle();
      check("full_rdy", bus.in_ready, 1'b0);
      check("full_valid", bus.out_valid, 1'b1);
      mode = 1;
      cycle();
      check("after_pop_rdy", bus.in_ready, 1'b1);
      mode = 0;
      cycle();
      check("refill_rdy", bus.in_ready, 1'b0);
      mode = 1;
      send("\n");
      run(60);
      check("x17_len", bus.line_len, 8'd17);
      repeat (300) tx_q.push_back(8'h78);
      tx_q.push_back(8'h0A);
      run(400);
      check("long_len", bus.line_len, 8'd255);
      check("long_ovf", bus.line_ovf, 1'b1);
      check("long_words", bus.line_words, 8'd1);
      check("long_xor", bus.line_xor, 8'h00);
      tx_q.push_back(8'hA1);
      tx_q.push_back(8'h6F);
      tx_q.push_back(8'h0A);
      run(20);
      check("ext_ext", bus.line_ext, 1'b1);
      check("ext_len", bus.line_len, 8'd2);
      check("ext_xor", bus.line_xor, 8'hCE);
      check("ext_words", bus.line_words, 8'd1);
      mode = 0;
      send("hello");
      repeat (5) cycle();
      tx_q.delete();
      do_reset(2);
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_len", bus.line_len, 8'd0);
      mode = 1;
      send("ok\n");
      run(20);
      check("ok_len", bus.line_len, 8'd2);
      check("ok_xor", bus.line_xor, 8'h04);
      check("ok_words", bus.line_words, 8'd1);
      mode = 2;
      gap_pct = 30;
      for (int l = 0; l < 40; l++) begin
         int n;
         n = $urandom_range(24);
         for (int k = 0; k < n; k++) tx_q.push_back(rnd_ch());
         tx_q.push_back(8'h0A);
      end
      run(5000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
